// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller.
// Imported by the controller, its ALU decoder and the memory interface.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_LUI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ERROR
  } state_t;

  typedef enum logic {
    CLS_I,
    CLS_R
  } alu_cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Unified instruction/data memory handshake between the
// controller (master) and the memory port (slave).
interface riscv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational funct decoder: opcode class, funct3 and funct7
// select the ALU operation and flag unsupported encodings.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_cls_t   i_cls,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [2:0] o_alu_ctrl,
  output logic       o_legal
);

  logic w_is_r;
  logic w_f7_zero;
  logic w_f7_alt;

  assign w_is_r    = (i_cls == CLS_R);
  assign w_f7_zero = (i_funct7 == 7'h00);
  assign w_f7_alt  = (i_funct7 == 7'h20);

  // I-type funct7 bits are immediate bits, so only R-type checks them
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_legal    = 1'b1;
    unique case (1'b1)
      (i_funct3 == 3'b000): begin
        o_alu_ctrl = (w_is_r && i_funct7[5]) ? ALU_SUB : ALU_ADD;
        o_legal    = !w_is_r || w_f7_zero || w_f7_alt;
      end
      (i_funct3 == 3'b111): begin
        o_alu_ctrl = ALU_AND;
        o_legal    = !w_is_r || w_f7_zero;
      end
      (i_funct3 == 3'b110): begin
        o_alu_ctrl = ALU_OR;
        o_legal    = !w_is_r || w_f7_zero;
      end
      (i_funct3 == 3'b010): begin
        o_alu_ctrl = ALU_SLT;
        o_legal    = !w_is_r || w_f7_zero;
      end
      default: begin
        o_alu_ctrl = ALU_ADD;
        o_legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// RV32I multi-cycle controller: sequences the shared ALU, register
// file, PC and unified memory port through the instruction phases.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  eq,
  riscv_multicycle_ctrl_if.master mem,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  reg_we,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_src,
  output logic [1:0]            result_src,
  output logic [2:0]            ALUctrl,
  output logic                  illegal
);

  state_t     r_state;
  logic       r_illegal;

  state_t     w_dec_next;
  alu_cls_t   w_cls;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [2:0] w_fn_ctrl;
  logic       w_fn_legal;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_adr_src;
  logic       w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_cls    = (w_opcode == OP_R) ? CLS_R : CLS_I;
  assign w_unused = ^{instr[24:15], instr[11:7]};

  alu_decoder u_alu_dec (
    .i_cls      (w_cls),
    .i_funct3   (w_funct3),
    .i_funct7   (w_funct7),
    .o_alu_ctrl (w_fn_ctrl),
    .o_legal    (w_fn_legal)
  );

  always_comb begin
    w_dec_next = S_ERROR;
    unique case (1'b1)
      (w_opcode == OP_LOAD),
      (w_opcode == OP_STORE):
        if (w_funct3 == 3'b010) w_dec_next = S_MEMADR;
      (w_opcode == OP_R):
        if (w_fn_legal) w_dec_next = S_EXEC_R;
      (w_opcode == OP_I):
        if (w_fn_legal) w_dec_next = S_EXEC_I;
      (w_opcode == OP_LUI):
        w_dec_next = S_LUI;
      (w_opcode == OP_BRANCH):
        if (w_funct3[2:1] == 2'b00) w_dec_next = S_BRANCH;
      (w_opcode == OP_JAL):
        w_dec_next = S_JAL;
      default:
        w_dec_next = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:
          if (mem.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= w_dec_next;
          if (w_dec_next == S_ERROR) r_illegal <= 1'b1;
        end
        S_MEMADR:
          r_state <= (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:
          if (mem.mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE:
          if (mem.mem_ready) r_state <= S_FETCH;
        S_EXEC_R:   r_state <= S_ALUWB;
        S_EXEC_I:   r_state <= S_ALUWB;
        S_LUI:      r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        S_ERROR:    r_state <= S_ERROR;
        default:    r_state <= S_ERROR;
      endcase
    end
  end

  // Strobes decode from state only, except the fetch and branch
  // PC writes; everything is held low while reset is asserted.
  always_comb begin
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_adr_src  = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    result_src = RES_ALUOUT;
    ALUctrl    = ALU_ADD;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          w_mem_req  = 1'b1;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          ir_we      = mem.mem_ready;
          pc_we      = mem.mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = (w_opcode == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          w_mem_req = 1'b1;
          w_adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_MDR;
          reg_we     = 1'b1;
        end
        S_MEMWRITE: begin
          w_mem_req = 1'b1;
          w_mem_we  = 1'b1;
          w_adr_src = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          ALUctrl   = w_fn_ctrl;
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_I;
          ALUctrl   = w_fn_ctrl;
        end
        S_LUI: begin
          alu_src_a = SRCA_ZERO;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_U;
        end
        S_ALUWB: begin
          result_src = RES_ALUOUT;
          reg_we     = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          ALUctrl    = ALU_SUB;
          result_src = RES_ALUOUT;
          pc_we      = eq ^ w_funct3[0];
        end
        S_JAL: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALUOUT;
          pc_we      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req = w_mem_req;
  assign mem.mem_we  = w_mem_we;
  assign mem.adr_src = w_adr_src;
  assign illegal     = r_illegal;

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control unit for the RV32I core. It sequences the shared ALU, register file, PC and unified instruction/data memory port through fetch, decode, execute, memory and writeback states. It drives `ALUctrl` and the datapath mux selects, and consumes the ALU `eq` flag for branches. It sits beside the ALU in the core top level, and the datapath registers its strobes directly.

## Interface
- `DATA_WIDTH`, 32, datapath width, carried for consistency; the controller only decodes `instr`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: instruction register contents (IR), valid from DECODE onward.
- `eq` in 1: ALU equality flag, 1 when `in1 - in2 == 0`.
- `mem_ready` in 1: memory accepted or returned data this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: the request is a write.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut register.
- `ir_we` out 1: load IR and old-PC from memory/PC.
- `pc_we` out 1: load PC from the `result_src` mux.
- `reg_we` out 1: register file write of rd.
- `alu_src_a` out 2: ALU in1 select. 00 = PC, 01 = old PC, 10 = rs1, 11 = zero.
- `alu_src_b` out 2: ALU in2 select. 00 = rs2, 01 = immediate, 10 = constant 4.
- `imm_src` out 3: immediate format. 0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
- `result_src` out 2: result mux select. 00 = ALUOut register, 01 = memory data register, 10 = live ALU output.
- `ALUctrl` out 3: ALU operation code. 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `illegal` out 1: sticky, set when an unsupported encoding is decoded.

## Operation
Supported instructions:
- R-type: add, sub, and, or, slt.
- I-type: addi, andi, ori, slti.
- Loads and stores: lw, sw.
- Branches: beq, bne.
- Jumps and upper immediates: jal, lui.

Output rules:
- Outputs not listed for a state are 0.
- `ALUctrl` defaults to 000 (add).

States:
- FETCH
  - Drives `mem_req`=1 and `adr_src`=0.
  - Drives `alu_src_a`=00, `alu_src_b`=10, `result_src`=10.
  - On `mem_ready`=1: `ir_we`=1 and `pc_we`=1 (PC ← PC+4), then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE
  - Drives `alu_src_a`=01, `alu_src_b`=01, and `imm_src`=J for jal, B otherwise, so ALUOut ← branch/jump target.
  - Next state by opcode: lw/sw → MEMADR; R → EXEC_R; I-ALU → EXEC_I; lui → LUI; branch → BRANCH; jal → JAL.
  - Any other opcode or funct goes to ERROR.
- MEMADR
  - Drives src_a = rs1, src_b = imm, `imm_src` = I for lw and S for sw.
  - Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `mem_req`=1, `adr_src`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_we`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `mem_we`=1, `adr_src`=1. Waits for `mem_ready`, then FETCH.
- EXEC_R: src_a = rs1, src_b = rs2, `ALUctrl` from the funct decoder, then ALUWB.
- EXEC_I: src_a = rs1, src_b = imm (I), `ALUctrl` from the funct decoder, then ALUWB.
- LUI: src_a = zero, src_b = imm (U), `ALUctrl` = add, then ALUWB.
- ALUWB: `result_src`=00, `reg_we`=1, then FETCH.
- BRANCH
  - Drives src_a = rs1, src_b = rs2, `ALUctrl` = sub, `result_src` = 00.
  - `pc_we` = `eq` XOR `funct3[0]`.
  - Next: FETCH.
- JAL
  - Drives src_a = old PC, src_b = 4, `result_src` = 00, `pc_we` = 1. This loads PC ← target and ALUOut ← PC+4.
  - Next: ALUWB.
- ERROR: all strobes 0 and `illegal` = 1. Held until `rst`.

Funct decode:
- funct3 000: add. For R-type with `funct7[5]` = 1 it is sub.
- funct3 111 → and, 110 → or, 010 → slt.
- Any other funct3, or R-type `funct7` not in {0x00, 0x20}, is illegal.

Handshake:
- `mem_req`, `mem_we` and `adr_src` stay stable until the cycle in which `mem_ready` is sampled 1.
- `mem_ready` is ignored outside the FETCH, MEMREAD and MEMWRITE states.

## Timing
- Reset (asynchronous, active-high):
  - State goes to FETCH and `illegal` clears.
  - While `rst` is high, every strobe is forced to 0.
  - `mem_req` rises combinationally once `rst` falls.
- Reset during any state, including a pending memory wait, abandons the operation with no register or PC write.
- Cycles per instruction with zero-wait memory:
  - beq/bne: 3.
  - R-type, I-type, lui, jal, sw: 4.
  - lw: 5.
  - Each memory wait cycle adds 1.
- Moore outputs, except two Mealy terms:
  - `ir_we` and `pc_we` in FETCH, gated by `mem_ready`.
  - `pc_we` in BRANCH, gated by `eq`.
- `illegal` is registered. It rises the cycle after DECODE sees the bad encoding.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111);
  - `ALUctrl` encodings;
  - the `alu_src_a`, `alu_src_b`, `imm_src` and `result_src` encodings.
- Sub-module `alu_decoder` is combinational: opcode class + funct3 + `funct7[5]` → `ALUctrl` and a legal flag.

## Test plan
- **Reset mid-fetch:** assert `rst` while in FETCH with `mem_ready`=0 → all strobes 0; after release `mem_req`=1 with `adr_src`=0.
- **R-type sub:** `instr` 0x402081B3 (sub x3,x1,x2), zero-wait memory → states FETCH, DECODE, EXEC_R, ALUWB; `ALUctrl`=001 in EXEC_R; `reg_we`=1 only in ALUWB.
- **Load with waits:** lw 0x00802283 with `mem_ready` delayed 2 cycles in both FETCH and MEMREAD → 9 cycles total; `adr_src`=1 held stable through the MEMREAD wait; `result_src`=01 in MEMWB.
- **Branches:** beq 0x00208463 with `eq`=1 → `pc_we`=1 in BRANCH; `eq`=0 → `pc_we`=0. bne (funct3 001) → the inverse of both results.
- **jal:** 0x008000EF → `imm_src`=3 in DECODE; `pc_we`=1 in JAL; `reg_we` in ALUWB with `result_src`=00.
- **Illegal encodings:** opcode 0x7F, or R-type with funct3 001 → `illegal`=1 the cycle after DECODE, stays 1 with no strobes until `rst`.
